// File: rtl/conv33_pkg.sv
// Shared constants for the 3x3 convolution pipeline.
package conv33_pkg;

    localparam int unsigned CONV33_WIDTH = 16;
    localparam int unsigned CROP_BORDER  = 2;

endpackage

// File: rtl/crop_fifo.sv
// Small synchronous FIFO holding cropped pixels; pointers carry one wrap bit.
module crop_fifo
    import conv33_pkg::*;
#(
    parameter int unsigned WIDTH = CONV33_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // When full, a same-cycle push lands in the slot being popped; dout still shows the old head.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_comb begin
        dout  = mem[rd_ptr[AW-1:0]];
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    end

endmodule

// File: rtl/conv33_output_crop.sv
// Crops the 2-pixel border of the 3x3 conv output stream and buffers kept pixels.
module conv33_output_crop
    import conv33_pkg::*;
#(
    parameter int unsigned IMG_W      = 64,
    parameter int unsigned IMG_H      = 64,
    parameter int unsigned WIDTH      = CONV33_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             frame_done,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_KEEP = CW'(CROP_BORDER);
    localparam logic [RW-1:0] ROW_KEEP = RW'(CROP_BORDER);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    logic             rst_meta;
    logic             rst_n_sync;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             keep;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [WIDTH-1:0] fifo_dout;

    // Assert asynchronously, release two clocks after reset rises.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta   <= 1'b0;
            rst_n_sync <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_n_sync <= rst_meta;
        end
    end

    always_comb begin
        keep      = in_valid && (col >= COL_KEEP) && (row >= ROW_KEEP);
        out_valid = !fifo_empty;
        fifo_pop  = out_valid && out_ready;
        fifo_push = keep && (!fifo_full || fifo_pop);
        out_data  = out_valid ? fifo_dout : '0;
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= in_valid && (col == COL_LAST) && (row == ROW_LAST);
            if (keep && fifo_full && !fifo_pop) overflow <= 1'b1;
            if (in_valid) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_ONE;
                end else begin
                    col <= col + COL_ONE;
                end
            end
        end
    end

    crop_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (rst_n_sync),
        .push  (fifo_push),
        .din   (in_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule
